// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants, encodings and the ID/EX register payload.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memwrite;
    logic              alusrc;
    logic              branch;
    logic              jump;
    logic [1:0]        resultsrc;
    logic [2:0]        alucontrol;
    logic              valid;
  } ex_reg_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode, MEM/WB feedback and execute-side signals of the operand stage.
// HAZARD_CNT_EN adds the hazard counter outputs.
interface ex_operand_stage_if;
  import riscv_pkg::*;

  logic [XLEN-1:0]   rd1_d, rd2_d, imm_d;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic              regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d;
  logic [1:0]        resultsrc_d;
  logic [2:0]        alucontrol_d;
  logic              valid_d;
  logic              flush_i;

  logic [XLEN-1:0]   alu_result_m;
  logic [REG_AW-1:0] rd_m;
  logic              regwrite_m;
  logic [XLEN-1:0]   result_w;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_w;

  logic [XLEN-1:0]   src_a_o, src_b_o, write_data_o;
  logic [2:0]        alucontrol_o;
  logic [REG_AW-1:0] rd_e_o;
  logic              regwrite_e_o, memwrite_e_o, branch_e_o, jump_e_o, valid_e_o;
  logic [1:0]        resultsrc_e_o;
  logic [1:0]        fwd_a_o, fwd_b_o;
  logic              stall_fd_o;
`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0]  lu_count_o, flush_count_o;
`endif

  modport master (
    output rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d,
           regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d,
           resultsrc_d, alucontrol_d, valid_d, flush_i,
           alu_result_m, rd_m, regwrite_m, result_w, rd_w, regwrite_w,
    input  src_a_o, src_b_o, write_data_o, alucontrol_o, rd_e_o,
           regwrite_e_o, memwrite_e_o, branch_e_o, jump_e_o, valid_e_o,
           resultsrc_e_o, fwd_a_o, fwd_b_o, stall_fd_o
`ifdef HAZARD_CNT_EN
          , lu_count_o, flush_count_o
`endif
  );

  modport slave (
    input  rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d,
           regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d,
           resultsrc_d, alucontrol_d, valid_d, flush_i,
           alu_result_m, rd_m, regwrite_m, result_w, rd_w, regwrite_w,
    output src_a_o, src_b_o, write_data_o, alucontrol_o, rd_e_o,
           regwrite_e_o, memwrite_e_o, branch_e_o, jump_e_o, valid_e_o,
           resultsrc_e_o, fwd_a_o, fwd_b_o, stall_fd_o
`ifdef HAZARD_CNT_EN
          , lu_count_o, flush_count_o
`endif
  );

endinterface

// File: rtl/fwd_unit.sv
// RAW forwarding select for the two E-stage sources; MEM beats WB, x0 never forwarded.
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic m_ok, w_ok;

  assign m_ok = regwrite_m && (rd_m != '0);
  assign w_ok = regwrite_w && (rd_w != '0);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (m_ok && (rd_m == rs1_e))      fwd_a = FWD_MEM;
    else if (w_ok && (rd_w == rs1_e)) fwd_a = FWD_WB;
    if (m_ok && (rd_m == rs2_e))      fwd_b = FWD_MEM;
    else if (w_ok && (rd_w == rs2_e)) fwd_b = FWD_WB;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding and load-use stall/bubble insertion.
// Optional HAZARD_CNT_EN adds saturating load-use and flush counters.
module ex_operand_stage
  import riscv_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  ex_operand_stage_if.slave bus
);

  ex_reg_t    e_q, e_d;
  logic       lu, bubble, stall;
  logic [1:0] fwd_a, fwd_b;
  logic [XLEN-1:0] src_a, wdata;

  // Load in E whose destination is read by a real instruction in decode
  assign lu = e_q.regwrite && (e_q.resultsrc == RESULT_LOAD) && (e_q.rd != '0) &&
              bus.valid_d && ((bus.rs1_d == e_q.rd) || (bus.rs2_d == e_q.rd));
  assign stall  = lu && !bus.flush_i;
  assign bubble = bus.flush_i || lu;

  always_comb begin
    e_d = '0;
    if (!bubble) begin
      e_d.rd1        = bus.rd1_d;
      e_d.rd2        = bus.rd2_d;
      e_d.imm        = bus.imm_d;
      e_d.rs1        = bus.rs1_d;
      e_d.rs2        = bus.rs2_d;
      e_d.rd         = bus.rd_d;
      e_d.regwrite   = bus.regwrite_d;
      e_d.memwrite   = bus.memwrite_d;
      e_d.alusrc     = bus.alusrc_d;
      e_d.branch     = bus.branch_d;
      e_d.jump       = bus.jump_d;
      e_d.resultsrc  = bus.resultsrc_d;
      e_d.alucontrol = bus.alucontrol_d;
      e_d.valid      = bus.valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  fwd_unit u_fwd (
    .rs1_e      (e_q.rs1),
    .rs2_e      (e_q.rs2),
    .rd_m       (bus.rd_m),
    .rd_w       (bus.rd_w),
    .regwrite_m (bus.regwrite_m),
    .regwrite_w (bus.regwrite_w),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always_comb begin
    src_a = e_q.rd1;
    wdata = e_q.rd2;
    case (fwd_a)
      FWD_MEM: src_a = bus.alu_result_m;
      FWD_WB:  src_a = bus.result_w;
      default: src_a = e_q.rd1;
    endcase
    case (fwd_b)
      FWD_MEM: wdata = bus.alu_result_m;
      FWD_WB:  wdata = bus.result_w;
      default: wdata = e_q.rd2;
    endcase
  end

  assign bus.src_a_o       = src_a;
  assign bus.write_data_o  = wdata;
  assign bus.src_b_o       = e_q.alusrc ? e_q.imm : wdata;
  assign bus.alucontrol_o  = e_q.alucontrol;
  assign bus.rd_e_o        = e_q.rd;
  assign bus.regwrite_e_o  = e_q.regwrite;
  assign bus.memwrite_e_o  = e_q.memwrite;
  assign bus.branch_e_o    = e_q.branch;
  assign bus.jump_e_o      = e_q.jump;
  assign bus.valid_e_o     = e_q.valid;
  assign bus.resultsrc_e_o = e_q.resultsrc;
  assign bus.fwd_a_o       = fwd_a;
  assign bus.fwd_b_o       = fwd_b;
  assign bus.stall_fd_o    = stall;

`ifdef HAZARD_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (lu_cnt_q != '1))          lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
      if (bus.flush_i && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.lu_count_o    = lu_cnt_q;
  assign bus.flush_count_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ex_operand_stage_if bus();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    bus.rd1_d = '0; bus.rd2_d = '0; bus.imm_d = '0;
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rd_d = '0;
    bus.regwrite_d = 1'b0; bus.memwrite_d = 1'b0; bus.alusrc_d = 1'b0;
    bus.branch_d = 1'b0; bus.jump_d = 1'b0; bus.resultsrc_d = 2'b00;
    bus.alucontrol_d = 3'b000; bus.valid_d = 1'b0; bus.flush_i = 1'b0;
    bus.alu_result_m = '0; bus.rd_m = '0; bus.regwrite_m = 1'b0;
    bus.result_w = '0; bus.rd_w = '0; bus.regwrite_w = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    bus.valid_d = 1'b1; bus.regwrite_d = 1'b1; bus.rd_d = 5'd7;
    bus.rs1_d = 5'd2; bus.rd1_d = 32'h1111; bus.alucontrol_d = ALU_SUB;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.valid_e_o !== 1'b0 || bus.rd_e_o !== 5'd0 || bus.regwrite_e_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: valid=%b rd=%0d rw=%b, required 0 0 0",
                         bus.valid_e_o, bus.rd_e_o, bus.regwrite_e_o);
    end
    n_chk++;
    if (bus.src_a_o !== 32'd0 || bus.src_b_o !== 32'd0 || bus.alucontrol_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_data: a=%h b=%h alu=%b, required 0", bus.src_a_o,
                         bus.src_b_o, bus.alucontrol_o);
    end
    n_chk++;
    if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00 || bus.stall_fd_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hz: fwd_a=%b fwd_b=%b stall=%b, required 00 00 0",
                         bus.fwd_a_o, bus.fwd_b_o, bus.stall_fd_o);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    n_chk++;
    if (bus.valid_e_o !== 1'b1 || bus.rd_e_o !== 5'd7 || bus.src_a_o !== 32'h1111 ||
        bus.alucontrol_o !== ALU_SUB) begin
      n_fail++; $display("FAIL reset_first_load: valid=%b rd=%0d a=%h alu=%b, required 1 7 1111 001",
                         bus.valid_e_o, bus.rd_e_o, bus.src_a_o, bus.alucontrol_o);
    end
  endtask

  task automatic test_ex_forward();
    clear_in();
    bus.valid_d = 1'b1; bus.rs1_d = 5'd5; bus.rd1_d = 32'hAAAA;
    step();
    bus.rd_m = 5'd5; bus.regwrite_m = 1'b1; bus.alu_result_m = 32'h1234;
    #1;
    n_chk++;
    if (bus.fwd_a_o !== FWD_MEM || bus.src_a_o !== 32'h1234) begin
      n_fail++; $display("FAIL fwd_mem: fwd_a=%b a=%h, required 10 1234", bus.fwd_a_o, bus.src_a_o);
    end
    bus.rd_w = 5'd5; bus.regwrite_w = 1'b1; bus.result_w = 32'h9;
    #1;
    n_chk++;
    if (bus.fwd_a_o !== FWD_MEM || bus.src_a_o !== 32'h1234) begin
      n_fail++; $display("FAIL fwd_mem_prio: fwd_a=%b a=%h, required 10 1234", bus.fwd_a_o, bus.src_a_o);
    end
    bus.regwrite_m = 1'b0;
    #1;
    n_chk++;
    if (bus.fwd_a_o !== FWD_WB || bus.src_a_o !== 32'h9) begin
      n_fail++; $display("FAIL fwd_wb: fwd_a=%b a=%h, required 01 9", bus.fwd_a_o, bus.src_a_o);
    end
    bus.regwrite_w = 1'b0;
    #1;
    n_chk++;
    if (bus.fwd_a_o !== FWD_RF || bus.src_a_o !== 32'hAAAA) begin
      n_fail++; $display("FAIL fwd_rf: fwd_a=%b a=%h, required 00 aaaa", bus.fwd_a_o, bus.src_a_o);
    end
  endtask

  task automatic test_x0_guard();
    clear_in();
    bus.valid_d = 1'b1; bus.imm_d = 32'hFFFF_FFFC;
    step();
    bus.rd_m = 5'd0; bus.regwrite_m = 1'b1; bus.alu_result_m = 32'hDEAD;
    bus.rd_w = 5'd0; bus.regwrite_w = 1'b1; bus.result_w = 32'hBEEF;
    #1;
    n_chk++;
    if (bus.fwd_b_o !== FWD_RF || bus.src_b_o !== 32'd0 || bus.write_data_o !== 32'd0) begin
      n_fail++; $display("FAIL x0_guard: fwd_b=%b b=%h wd=%h, required 00 0 0",
                         bus.fwd_b_o, bus.src_b_o, bus.write_data_o);
    end
    bus.alusrc_d = 1'b1; bus.rs2_d = 5'd6; bus.rd2_d = 32'h77;
    bus.rd_w = 5'd6;
    step();
    n_chk++;
    if (bus.src_b_o !== 32'hFFFF_FFFC || bus.fwd_b_o !== FWD_WB || bus.write_data_o !== 32'hBEEF) begin
      n_fail++; $display("FAIL imm_sel: b=%h fwd_b=%b wd=%h, required fffffffc 01 beef",
                         bus.src_b_o, bus.fwd_b_o, bus.write_data_o);
    end
  endtask

  task automatic test_load_use();
    int stalls;
    clear_in();
    // lw x3 enters E
    bus.valid_d = 1'b1; bus.regwrite_d = 1'b1; bus.resultsrc_d = RESULT_LOAD; bus.rd_d = 5'd3;
    step();
    // add x4, x3, x1 in decode
    bus.resultsrc_d = RESULT_ALU; bus.rd_d = 5'd4; bus.rs1_d = 5'd3; bus.rs2_d = 5'd1;
    bus.rd1_d = 32'h0BAD; bus.rd2_d = 32'h10;
    #1;
    stalls = 0;
    if (bus.stall_fd_o === 1'b1) stalls++;
    step();
    n_chk++;
    if (bus.valid_e_o !== 1'b0 || bus.regwrite_e_o !== 1'b0 || bus.rd_e_o !== 5'd0) begin
      n_fail++; $display("FAIL lu_bubble: valid=%b rw=%b rd=%0d, required 0 0 0",
                         bus.valid_e_o, bus.regwrite_e_o, bus.rd_e_o);
    end
    if (bus.stall_fd_o === 1'b1) stalls++;
    bus.rd_m = 5'd3; bus.regwrite_m = 1'b1; bus.alu_result_m = 32'h100;
    step();
    bus.rd_m = 5'd0; bus.regwrite_m = 1'b0;
    bus.rd_w = 5'd3; bus.regwrite_w = 1'b1; bus.result_w = 32'h55;
    #1;
    if (bus.stall_fd_o === 1'b1) stalls++;
    n_chk++;
    if (stalls !== 1) begin
      n_fail++; $display("FAIL lu_stall_len: %0d stall cycles, required 1", stalls);
    end
    n_chk++;
    if (bus.valid_e_o !== 1'b1 || bus.rd_e_o !== 5'd4 || bus.fwd_a_o !== FWD_WB ||
        bus.src_a_o !== 32'h55 || bus.src_b_o !== 32'h10) begin
      n_fail++; $display("FAIL lu_resume: valid=%b rd=%0d fwd_a=%b a=%h b=%h, required 1 4 01 55 10",
                         bus.valid_e_o, bus.rd_e_o, bus.fwd_a_o, bus.src_a_o, bus.src_b_o);
    end
    // load into x0 never stalls
    clear_in();
    bus.valid_d = 1'b1; bus.regwrite_d = 1'b1; bus.resultsrc_d = RESULT_LOAD;
    step();
    bus.resultsrc_d = RESULT_ALU; bus.rd_d = 5'd4;
    #1;
    n_chk++;
    if (bus.stall_fd_o !== 1'b0) begin
      n_fail++; $display("FAIL lu_x0: stall=%b, required 0", bus.stall_fd_o);
    end
  endtask

  task automatic test_flush();
    clear_in();
    bus.valid_d = 1'b1; bus.regwrite_d = 1'b1; bus.resultsrc_d = RESULT_LOAD; bus.rd_d = 5'd3;
    step();
    bus.resultsrc_d = RESULT_ALU; bus.rd_d = 5'd4; bus.rs1_d = 5'd3; bus.flush_i = 1'b1;
    #1;
    n_chk++;
    if (bus.stall_fd_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_lu_stall: stall=%b, required 0", bus.stall_fd_o);
    end
    step();
    n_chk++;
    if (bus.valid_e_o !== 1'b0 || bus.regwrite_e_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_lu_bubble: valid=%b rw=%b, required 0 0",
                         bus.valid_e_o, bus.regwrite_e_o);
    end
    bus.rs1_d = 5'd1; bus.memwrite_d = 1'b1; bus.branch_d = 1'b1; bus.jump_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if (bus.valid_e_o !== 1'b0 || bus.memwrite_e_o !== 1'b0 || bus.branch_e_o !== 1'b0 ||
          bus.jump_e_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_bubble%0d: valid=%b mw=%b br=%b j=%b, required 0",
                           i, bus.valid_e_o, bus.memwrite_e_o, bus.branch_e_o, bus.jump_e_o);
      end
    end
    bus.flush_i = 1'b0;
    step();
    n_chk++;
    if (bus.valid_e_o !== 1'b1 || bus.memwrite_e_o !== 1'b1 || bus.jump_e_o !== 1'b1 ||
        bus.rd_e_o !== 5'd4) begin
      n_fail++; $display("FAIL flush_resume: valid=%b mw=%b j=%b rd=%0d, required 1 1 1 4",
                         bus.valid_e_o, bus.memwrite_e_o, bus.jump_e_o, bus.rd_e_o);
    end
  endtask

`ifdef HAZARD_CNT_EN
  task automatic test_counters();
    clear_in();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_in();
      bus.valid_d = 1'b1; bus.regwrite_d = 1'b1; bus.resultsrc_d = RESULT_LOAD; bus.rd_d = 5'd3;
      step();
      bus.resultsrc_d = RESULT_ALU; bus.rd_d = 5'd4; bus.rs2_d = 5'd3;
      step();
      step();
    end
    clear_in();
    bus.valid_d = 1'b1; bus.flush_i = 1'b1;
    step();
    step();
    bus.flush_i = 1'b0;
    step();
    n_chk++;
    if (bus.lu_count_o !== 32'd3 || bus.flush_count_o !== 32'd2) begin
      n_fail++; $display("FAIL counters: lu=%0d flush=%0d, required 3 2",
                         bus.lu_count_o, bus.flush_count_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.lu_count_o !== 32'd0 || bus.flush_count_o !== 32'd0) begin
      n_fail++; $display("FAIL counters_reset: lu=%0d flush=%0d, required 0 0",
                         bus.lu_count_o, bus.flush_count_o);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
`endif

  initial begin
    n_chk = 0;
    n_fail = 0;
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_ex_forward();
    test_x0_guard();
    test_load_use();
    test_flush();
`ifdef HAZARD_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
